// File: rtl/ccff_bitstream_loader.sv
// ccff_bitstream_loader: streams a byte-wide bitstream LSB first into a
// configuration flip-flop chain, with an optional recirculating readback.
// Optional feature macro: CCFF_BITSTREAM_LOADER_READBACK_EN (readback check).
// Ports:
//   prog_clk, prog_reset            clock, synchronous active-high reset
//   start                           begin a load (sampled in IDLE only)
//   bs_data, bs_valid, bs_ready     bitstream byte handshake
//   ccff_head, ccff_tail            chain serial in / serial out
//   ccff_shift_en                   chain capture enable
//   busy, done, error               status (error sticky until next start)
module ccff_bitstream_loader #(
    parameter int CHAIN_LEN = 64
) (
    input  logic       prog_clk,
    input  logic       prog_reset,
    input  logic       start,
    input  logic [7:0] bs_data,
    input  logic       bs_valid,
    output logic       bs_ready,
    output logic       ccff_head,
    input  logic       ccff_tail,
    output logic       ccff_shift_en,
    output logic       busy,
    output logic       done,
    output logic       error
);

    localparam logic [15:0] LEN  = 16'(CHAIN_LEN);
    localparam logic [15:0] LAST = 16'(CHAIN_LEN - 1);

`ifdef CCFF_BITSTREAM_LOADER_READBACK_EN
    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_LOAD     = 2'd1,
        ST_READBACK = 2'd2,
        ST_DONE     = 2'd3
    } state_t;
`else
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_DONE = 2'd3
    } state_t;
`endif

    state_t      state_q, state_d;
    logic [7:0]  buf_q, buf_d;
    logic [3:0]  buf_cnt_q, buf_cnt_d;
    // chain bits not yet pulled into the buffer
    logic [15:0] left_q, left_d;
    logic [15:0] bit_cnt_q, bit_cnt_d;
    logic [15:0] ones_q, ones_d;
    logic        head_q, head_d;
    logic        shift_q, shift_d;

    logic        accept;
    logic [3:0]  take;

`ifdef CCFF_BITSTREAM_LOADER_READBACK_EN
    logic [15:0] rb_cnt_q, rb_cnt_d;
    logic [15:0] rb_ones_q, rb_ones_d;
    logic        error_q, error_d;
    logic [15:0] rb_ones_inc;
`endif

    assign bs_ready = (state_q == ST_LOAD) && (buf_cnt_q == 4'd0)
                      && (left_q != 16'd0);
    assign accept   = bs_valid && bs_ready;
    // the last byte may carry fewer useful bits than 8
    assign take     = (left_q >= 16'd8) ? 4'd8 : left_q[3:0];
    assign busy     = (state_q != ST_IDLE);
    assign done     = (state_q == ST_DONE);

`ifdef CCFF_BITSTREAM_LOADER_READBACK_EN
    assign rb_ones_inc   = rb_ones_q + {15'd0, ccff_tail};
    // readback recirculates tail into head so the chain ends restored
    assign ccff_head     = (state_q == ST_READBACK) ? ccff_tail : head_q;
    assign ccff_shift_en = shift_q || (state_q == ST_READBACK);
    assign error         = error_q;
`else
    logic unused_sig;
    assign unused_sig    = ccff_tail ^ (^ones_q);
    assign ccff_head     = head_q;
    assign ccff_shift_en = shift_q;
    assign error         = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        buf_d     = buf_q;
        buf_cnt_d = buf_cnt_q;
        left_d    = left_q;
        bit_cnt_d = bit_cnt_q;
        ones_d    = ones_q;
        head_d    = head_q;
        shift_d   = 1'b0;
`ifdef CCFF_BITSTREAM_LOADER_READBACK_EN
        rb_cnt_d  = rb_cnt_q;
        rb_ones_d = rb_ones_q;
        error_d   = error_q;
`endif
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d   = ST_LOAD;
                    buf_cnt_d = 4'd0;
                    left_d    = LEN;
                    bit_cnt_d = 16'd0;
                    ones_d    = 16'd0;
`ifdef CCFF_BITSTREAM_LOADER_READBACK_EN
                    rb_cnt_d  = 16'd0;
                    rb_ones_d = 16'd0;
                    error_d   = 1'b0;
`endif
                end
            end
            ST_LOAD: begin
                // account for the bit the chain captures this cycle
                if (shift_q) begin
                    bit_cnt_d = bit_cnt_q + 16'd1;
                    ones_d    = ones_q + {15'd0, head_q};
                    if (bit_cnt_q == LAST) begin
`ifdef CCFF_BITSTREAM_LOADER_READBACK_EN
                        state_d = ST_READBACK;
`else
                        state_d = ST_DONE;
`endif
                    end
                end
                // an accepted byte bypasses its bit 0 straight to the
                // head register so shifting stays gapless across bytes
                if (accept) begin
                    head_d    = bs_data[0];
                    shift_d   = 1'b1;
                    buf_d     = {1'b0, bs_data[7:1]};
                    buf_cnt_d = take - 4'd1;
                    left_d    = left_q - {12'd0, take};
                end else if (buf_cnt_q != 4'd0) begin
                    head_d    = buf_q[0];
                    shift_d   = 1'b1;
                    buf_d     = {1'b0, buf_q[7:1]};
                    buf_cnt_d = buf_cnt_q - 4'd1;
                end
            end
`ifdef CCFF_BITSTREAM_LOADER_READBACK_EN
            ST_READBACK: begin
                rb_cnt_d  = rb_cnt_q + 16'd1;
                rb_ones_d = rb_ones_inc;
                if (rb_cnt_q == LAST) begin
                    state_d = ST_DONE;
                    error_d = (rb_ones_inc != ones_q);
                end
            end
`endif
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge prog_clk) begin
        if (prog_reset) begin
            state_q   <= ST_IDLE;
            buf_q     <= 8'd0;
            buf_cnt_q <= 4'd0;
            left_q    <= 16'd0;
            bit_cnt_q <= 16'd0;
            ones_q    <= 16'd0;
            head_q    <= 1'b0;
            shift_q   <= 1'b0;
`ifdef CCFF_BITSTREAM_LOADER_READBACK_EN
            rb_cnt_q  <= 16'd0;
            rb_ones_q <= 16'd0;
            error_q   <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            buf_q     <= buf_d;
            buf_cnt_q <= buf_cnt_d;
            left_q    <= left_d;
            bit_cnt_q <= bit_cnt_d;
            ones_q    <= ones_d;
            head_q    <= head_d;
            shift_q   <= shift_d;
`ifdef CCFF_BITSTREAM_LOADER_READBACK_EN
            rb_cnt_q  <= rb_cnt_d;
            rb_ones_q <= rb_ones_d;
            error_q   <= error_d;
`endif
        end
    end

endmodule

// File: tb/tb_ccff_bitstream_loader.sv
// Bench for ccff_bitstream_loader: a 20-bit and a 1-bit chain model,
// directed scenarios with hand-computed expectations.
`timescale 1ns/1ps
module tb_ccff_bitstream_loader;

    localparam logic [19:0] EXP = 20'hA53CF;
`ifdef CCFF_BITSTREAM_LOADER_READBACK_EN
    localparam int SHIFTS  = 40;
    localparam int SHIFTS1 = 2;
`else
    localparam int SHIFTS  = 20;
    localparam int SHIFTS1 = 1;
`endif

    logic       prog_clk = 1'b0;
    logic       prog_reset = 1'b1;
    logic       start = 1'b0;
    logic [7:0] bs_data = 8'd0;
    logic       bs_valid = 1'b0;
    logic       bs_ready, ccff_head, ccff_tail, ccff_shift_en;
    logic       busy, done, error;

    logic       start1 = 1'b0;
    logic [7:0] bs_data1 = 8'd0;
    logic       bs_valid1 = 1'b0;
    logic       bs_ready1, head1, tail1, shift1;
    logic       busy1, done1, error1;

    logic [19:0] chain = '0;
    logic        chain1 = 1'b0;
    logic        force_tail0 = 1'b0;

    int checks = 0;
    int errors = 0;

    always #5 prog_clk = ~prog_clk;

    assign ccff_tail = force_tail0 ? 1'b0 : chain[19];
    assign tail1     = chain1;

    ccff_bitstream_loader #(.CHAIN_LEN(20)) dut (
        .prog_clk(prog_clk), .prog_reset(prog_reset), .start(start),
        .bs_data(bs_data), .bs_valid(bs_valid), .bs_ready(bs_ready),
        .ccff_head(ccff_head), .ccff_tail(ccff_tail),
        .ccff_shift_en(ccff_shift_en), .busy(busy), .done(done),
        .error(error)
    );

    ccff_bitstream_loader #(.CHAIN_LEN(1)) dut1 (
        .prog_clk(prog_clk), .prog_reset(prog_reset), .start(start1),
        .bs_data(bs_data1), .bs_valid(bs_valid1), .bs_ready(bs_ready1),
        .ccff_head(head1), .ccff_tail(tail1),
        .ccff_shift_en(shift1), .busy(busy1), .done(done1),
        .error(error1)
    );

    int   cyc = 0, shift_cnt = 0, first_sh = -1, last_sh = -1;
    int   done_cnt = 0;
    logic mon_clr = 1'b0;

    always @(posedge prog_clk) begin
        cyc = cyc + 1;
        if (mon_clr) begin
            shift_cnt = 0;
            first_sh  = -1;
            last_sh   = -1;
            done_cnt  = 0;
        end else begin
            if (ccff_shift_en) begin
                chain <= {chain[18:0], ccff_head};
                shift_cnt = shift_cnt + 1;
                if (first_sh < 0) first_sh = cyc;
                last_sh = cyc;
            end
            if (done) done_cnt = done_cnt + 1;
        end
    end

    int   cyc1 = 0, sh1_cnt = 0, sh1_cyc = 0, done1_cyc = -100;
    logic clr1 = 1'b0;

    always @(posedge prog_clk) begin
        cyc1 = cyc1 + 1;
        if (clr1) begin
            sh1_cnt   = 0;
            sh1_cyc   = 0;
            done1_cyc = -100;
        end else begin
            if (shift1) begin
                chain1 <= head1;
                sh1_cnt = sh1_cnt + 1;
                sh1_cyc = cyc1;
            end
            if (done1) done1_cyc = cyc1;
        end
    end

    // Streams A5,3C,0F; optional stall, reset, forced tail, extra start.
    task automatic drive_load(input int stall_len, input int reset_at,
                              input bit force_rb, input bit start_mid,
                              output bit timed_out);
        logic [7:0] bytes [3];
        int idx, stall_left, n;
        bit stalled, sm, fin;
        bytes[0] = 8'hA5;
        bytes[1] = 8'h3C;
        bytes[2] = 8'h0F;
        idx = 0; stall_left = 0; n = 0;
        stalled = 0; sm = 0; fin = 0;
        timed_out = 0;
        @(negedge prog_clk);
        start = 1'b1;
        mon_clr = 1'b1;
        @(negedge prog_clk);
        start = 1'b0;
        mon_clr = 1'b0;
        while (!fin) begin
            if (reset_at > 0 && shift_cnt == reset_at) begin
                prog_reset = 1'b1;
                bs_valid = 1'b0;
                fin = 1;
            end else if (done) begin
                fin = 1;
            end else if (n > 400) begin
                timed_out = 1;
                fin = 1;
            end else begin
                start = start_mid && shift_cnt == 5 && !sm;
                if (start) sm = 1;
                force_tail0 = force_rb && shift_cnt == 20;
                if (stall_len > 0 && idx == 1 && bs_ready && !stalled) begin
                    stalled = 1;
                    stall_left = stall_len;
                end
                if (stall_left > 0) begin
                    bs_valid = 1'b0;
                    stall_left--;
                end else if (idx < 3) begin
                    bs_valid = 1'b1;
                    bs_data = bytes[idx];
                end else begin
                    bs_valid = 1'b0;
                end
                if (bs_valid && bs_ready) idx++;
                n++;
                @(negedge prog_clk);
            end
        end
        bs_valid = 1'b0;
        start = 1'b0;
        force_tail0 = 1'b0;
    endtask

    task automatic test_reset;
        prog_reset = 1'b1;
        repeat (3) @(negedge prog_clk);
        checks++;
        if (busy !== 1'b0) begin
            errors++; $display("FAIL reset_busy: got %b expected 0", busy);
        end
        checks++;
        if (bs_ready !== 1'b0) begin
            errors++; $display("FAIL reset_ready: got %b expected 0", bs_ready);
        end
        checks++;
        if (ccff_shift_en !== 1'b0) begin
            errors++;
            $display("FAIL reset_shift: got %b expected 0", ccff_shift_en);
        end
        checks++;
        if (ccff_head !== 1'b0) begin
            errors++; $display("FAIL reset_head: got %b expected 0", ccff_head);
        end
        checks++;
        if (done !== 1'b0 || error !== 1'b0) begin
            errors++;
            $display("FAIL reset_done_err: got %b%b expected 00", done, error);
        end
        checks++;
        if (busy1 !== 1'b0 || shift1 !== 1'b0) begin
            errors++;
            $display("FAIL reset_dut1: got %b%b expected 00", busy1, shift1);
        end
        prog_reset = 1'b0;
        @(negedge prog_clk);
    endtask

    task automatic test_back_to_back;
        bit to;
        drive_load(0, 0, 0, 0, to);
        @(negedge prog_clk);
        checks++;
        if (to) begin
            errors++; $display("FAIL b2b_timeout: got 1 expected 0");
        end
        checks++;
        if (chain !== EXP) begin
            errors++; $display("FAIL b2b_chain: got %h expected %h", chain, EXP);
        end
        checks++;
        if (shift_cnt != SHIFTS) begin
            errors++;
            $display("FAIL b2b_shifts: got %0d expected %0d", shift_cnt, SHIFTS);
        end
        checks++;
        if (last_sh - first_sh + 1 - shift_cnt != 0) begin
            errors++;
            $display("FAIL b2b_gaps: got %0d expected 0",
                     last_sh - first_sh + 1 - shift_cnt);
        end
        checks++;
        if (done_cnt != 1) begin
            errors++; $display("FAIL b2b_done: got %0d expected 1", done_cnt);
        end
        checks++;
        if (error !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL b2b_err_busy: got %b%b expected 00", error, busy);
        end
    endtask

    task automatic test_stall;
        bit to;
        drive_load(5, 0, 0, 0, to);
        @(negedge prog_clk);
        checks++;
        if (to) begin
            errors++; $display("FAIL stall_timeout: got 1 expected 0");
        end
        checks++;
        if (chain !== EXP) begin
            errors++;
            $display("FAIL stall_chain: got %h expected %h", chain, EXP);
        end
        checks++;
        if (shift_cnt != SHIFTS) begin
            errors++;
            $display("FAIL stall_shifts: got %0d expected %0d",
                     shift_cnt, SHIFTS);
        end
        checks++;
        if (last_sh - first_sh + 1 - shift_cnt != 5) begin
            errors++;
            $display("FAIL stall_gaps: got %0d expected 5",
                     last_sh - first_sh + 1 - shift_cnt);
        end
    endtask

    task automatic test_ignore;
        bit to;
        bs_valid = 1'b1;
        bs_data = 8'hFF;
        for (int i = 0; i < 3; i++) begin
            @(negedge prog_clk);
            checks++;
            if (bs_ready !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL idle_valid: got %b%b expected 00",
                         bs_ready, busy);
            end
        end
        bs_valid = 1'b0;
        drive_load(0, 0, 0, 1, to);
        @(negedge prog_clk);
        checks++;
        if (to || shift_cnt != SHIFTS) begin
            errors++;
            $display("FAIL ign_shifts: got %0d expected %0d",
                     shift_cnt, SHIFTS);
        end
        checks++;
        if (chain !== EXP || done_cnt != 1) begin
            errors++;
            $display("FAIL ign_chain: got %h/%0d expected %h/1",
                     chain, done_cnt, EXP);
        end
    endtask

    task automatic test_reset_mid_load;
        bit to;
        drive_load(0, 9, 0, 0, to);
        @(negedge prog_clk);
        checks++;
        if (ccff_shift_en !== 1'b0 || busy !== 1'b0 || bs_ready !== 1'b0) begin
            errors++;
            $display("FAIL abort: got %b%b%b expected 000",
                     ccff_shift_en, busy, bs_ready);
        end
        prog_reset = 1'b0;
        @(negedge prog_clk);
        drive_load(0, 0, 0, 0, to);
        @(negedge prog_clk);
        checks++;
        if (to || chain !== EXP || shift_cnt != SHIFTS || done_cnt != 1) begin
            errors++;
            $display("FAIL reload: got %h/%0d/%0d expected %h/%0d/1",
                     chain, shift_cnt, done_cnt, EXP, SHIFTS);
        end
    endtask

`ifdef CCFF_BITSTREAM_LOADER_READBACK_EN
    task automatic test_readback_error;
        bit to;
        drive_load(0, 0, 1, 0, to);
        @(negedge prog_clk);
        checks++;
        if (to || error !== 1'b1) begin
            errors++; $display("FAIL rb_error: got %b expected 1", error);
        end
        @(negedge prog_clk);
        start = 1'b1;
        @(negedge prog_clk);
        start = 1'b0;
        checks++;
        if (error !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL rb_clear: got %b%b expected 01", error, busy);
        end
        drive_load(0, 0, 0, 0, to);
        @(negedge prog_clk);
        checks++;
        if (to || error !== 1'b0 || chain !== EXP) begin
            errors++;
            $display("FAIL rb_ok: got %b/%h expected 0/%h", error, chain, EXP);
        end
    endtask
`endif

    task automatic test_chain_len1;
        int n;
        @(negedge prog_clk);
        start1 = 1'b1;
        clr1 = 1'b1;
        @(negedge prog_clk);
        start1 = 1'b0;
        clr1 = 1'b0;
        bs_data1 = 8'hFE;
        bs_valid1 = 1'b1;
        n = 0;
        while (!bs_ready1 && n < 20) begin
            @(negedge prog_clk);
            n++;
        end
        @(negedge prog_clk);
        bs_valid1 = 1'b0;
        n = 0;
        while (!done1 && n < 20) begin
            @(negedge prog_clk);
            n++;
        end
        checks++;
        if (done1 !== 1'b1) begin
            errors++; $display("FAIL len1_done: got %b expected 1", done1);
        end
        @(negedge prog_clk);
        checks++;
        if (sh1_cnt != SHIFTS1) begin
            errors++;
            $display("FAIL len1_shifts: got %0d expected %0d",
                     sh1_cnt, SHIFTS1);
        end
        checks++;
        if (chain1 !== 1'b0) begin
            errors++; $display("FAIL len1_bit: got %b expected 0", chain1);
        end
        checks++;
        if (done1_cyc - sh1_cyc != 1) begin
            errors++;
            $display("FAIL len1_latency: got %0d expected 1",
                     done1_cyc - sh1_cyc);
        end
        checks++;
        if (busy1 !== 1'b0 || error1 !== 1'b0) begin
            errors++;
            $display("FAIL len1_idle: got %b%b expected 00", busy1, error1);
        end
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_stall();
        test_ignore();
        test_reset_mid_load();
`ifdef CCFF_BITSTREAM_LOADER_READBACK_EN
        test_readback_error();
`endif
        test_chain_len1();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ccff_bitstream_loader.md
CCFF_BITSTREAM_LOADER -- requirements
Module: ccff_bitstream_loader

Interface
REQ-001 Parameter CHAIN_LEN, default 64: number of configuration flip-flops in the driven ccff chain (legal range 1..65535).
REQ-002 prog_clk  input  1  programming clock; all state updates on its rising edge.
REQ-003 prog_reset  input  1  synchronous, active-high reset.
REQ-004 start  input  1  one-cycle pulse; begins a load when sampled in IDLE.
REQ-005 bs_data  input  8  bitstream byte.
REQ-006 bs_valid  input  1  bs_data valid.
REQ-007 bs_ready  output  1  loader accepts a byte this cycle.
REQ-008 ccff_head  output  1  serial data into the chain head.
REQ-009 ccff_tail  input  1  serial data from the chain tail.
REQ-010 ccff_shift_en  output  1  chain clock-gate enable; the chain captures ccff_head on the prog_clk edge ending any cycle in which this signal is 1.
REQ-011 busy  output  1  high in any state other than IDLE.
REQ-012 done  output  1  one-cycle pulse on completion.
REQ-013 error  output  1  sticky readback mismatch flag.

Function
REQ-014 The FSM SHALL have the states IDLE, LOAD, READBACK (macro-dependent) and DONE.
REQ-015 IDLE->LOAD on start; the bit counter and ones counter SHALL clear and error SHALL clear on the same edge.
REQ-016 The loader SHALL hold a one-byte buffer; bs_ready SHALL equal (state==LOAD) AND buffer empty AND bytes_remaining>0; a transfer SHALL occur when bs_valid AND bs_ready.
REQ-017 Bytes SHALL be shifted out LSB first, one bit per ccff_shift_en cycle; the total number of bits shifted SHALL be exactly CHAIN_LEN, which requires ceil(CHAIN_LEN/8) bytes.
REQ-018 Bits of the final byte beyond CHAIN_LEN SHALL be discarded without shifting.
REQ-019 ccff_head and ccff_shift_en SHALL be registered during LOAD; when the buffer is empty (source underflow), ccff_shift_en SHALL be 0 and chain contents SHALL be unchanged.
REQ-020 The first bit SHALL reach ccff_shift_en=1 no earlier than one cycle after its byte is accepted; a new byte MAY be accepted in the cycle in which the last bit of the previous byte is shifted, giving gapless shifting at full input rate.
REQ-021 During LOAD, the ones counter SHALL increment for every shifted 1.
REQ-022 After the CHAIN_LEN-th shift, LOAD SHALL exit to READBACK (macro on) or DONE (macro off).
REQ-023 DONE SHALL last one cycle with done=1 and then return to IDLE; busy=0 in IDLE.
REQ-024 start while busy SHALL be ignored; bs_valid outside LOAD SHALL be ignored (bs_ready=0).

Reset
REQ-025 prog_reset SHALL force IDLE, empty the buffer, and clear the counters, with ccff_head=0, ccff_shift_en=0, bs_ready=0, busy=0, done=0, and error=0.
REQ-026 Reset mid-LOAD or mid-READBACK SHALL abort immediately, with no further shifts; the chain contents are then undefined and a new start is required.

Configuration
REQ-027 Macro CCFF_BITSTREAM_LOADER_READBACK_EN: when defined, the READBACK state is compiled in; when undefined, READBACK logic and its counter are absent and error is tied to 0.
REQ-028 In READBACK, ccff_shift_en SHALL be 1 for exactly CHAIN_LEN consecutive cycles, and ccff_head SHALL equal ccff_tail combinationally, so that the chain recirculates and ends with its contents restored.
REQ-029 During READBACK, a second counter SHALL count ones sampled on ccff_tail in shift cycles.
REQ-030 On READBACK exit to DONE, error SHALL be set if the two counts differ.

Verification
REQ-031 CHAIN_LEN=20, bytes 0xA5,0x3C,0x0F streamed back-to-back -> chain model holds bits 1,0,1,0,0,1,0,1,0,0,1,1,1,1,0,0,1,1,1,1 (first-shifted first); exactly 20 shift cycles occur; done pulses once.
REQ-032 Same stimulus with bs_valid deasserted for 5 cycles mid-byte -> ccff_shift_en stays 0 for those cycles, and the final chain contents are identical to REQ-031.
REQ-033 Macro on, correct chain model -> 40 total shift cycles occur, the chain is restored, and error=0; with a tail bit forced to 0 during READBACK -> error=1 after done, cleared on the next start.
REQ-034 prog_reset asserted after the 9th shift -> the next cycle has ccff_shift_en=0, busy=0, and bs_ready=0; a subsequent full load completes normally.
REQ-035 start pulsed during LOAD and bs_valid in IDLE -> both are ignored, and the shift count remains CHAIN_LEN.
REQ-036 CHAIN_LEN=1, byte 0xFE -> one shift of 0 occurs, and done is asserted 1 cycle after the shift (macro off).
